// File: rtl/epu_block_sched_if.sv
// Handshake/bus bundle between the EPU block scheduler and its neighbours.
// The master drives the start/flow-control inputs; the scheduler is the slave.
interface epu_block_sched_if #(
  parameter int ADDR_W    = 12,
  parameter int BLOCK_NUM = 64
);
  localparam int BIDX_W = $clog2(BLOCK_NUM + 1);

  logic              start;
  logic              buf_full;
  logic              ch_done;
  logic [ADDR_W-1:0] addr;
  logic              addr_valid;
  logic              data_valid;
  logic [2:0]        mode;
  logic [BIDX_W-1:0] block_idx;
  logic              busy;
  logic              done;
  logic [15:0]       perf_hold;

  modport master (
    output start, buf_full, ch_done,
    input  addr, addr_valid, data_valid, mode, block_idx, busy, done, perf_hold
  );

  modport slave (
    input  start, buf_full, ch_done,
    output addr, addr_valid, data_valid, mode, block_idx, busy, done, perf_hold
  );
endinterface

// File: rtl/epu_block_sched.sv
// EPU block/channel fetch scheduler: walks blocks, sequences channels, issues read addresses.
// Optional hold-cycle performance counter enabled by defining EPU_SCHED_PERF_EN.
module epu_block_sched #(
  parameter int ADDR_W          = 12,
  parameter int BLOCK_NUM       = 64,
  parameter int WORDS_PER_BLOCK = 16,
  parameter int NUM_CH          = 3,
  parameter int RD_LAT          = 2
) (
  input  logic                 clk,
  input  logic                 rst,
  epu_block_sched_if.slave     bus
);
  localparam int OFF_W  = $clog2(WORDS_PER_BLOCK);
  localparam int BIDX_W = $clog2(BLOCK_NUM + 1);

  typedef enum logic [1:0] {IDLE, FETCH, HOLD, DONE} state_t;

  state_t             state, state_n;
  logic [ADDR_W-1:0]  base, base_n;
  logic [OFF_W-1:0]   off, off_n;
  logic [2:0]         mode, mode_n;
  logic [BIDX_W-1:0]  block_idx, bidx_n;
  logic               done_n;
  logic               accept;
  logic [ADDR_W-1:0]  addr_q;
  logic               addr_valid_q;
  logic               done_q;
  logic [RD_LAT-1:0]  dv_sr;

  // ch_done is only meaningful while actively working on a block
  assign accept = bus.ch_done && (state == FETCH || state == HOLD);

  always_comb begin
    state_n = state;
    base_n  = base;
    off_n   = off;
    mode_n  = mode;
    bidx_n  = block_idx;
    done_n  = 1'b0;
    case (state)
      IDLE: begin
        if (bus.start) begin
          state_n = FETCH;
          base_n  = '0;
          off_n   = '0;
          mode_n  = 3'd1;
          bidx_n  = '0;
        end
      end
      FETCH: begin
        if (bus.buf_full) begin
          state_n = HOLD;
          off_n   = '0;
        end else begin
          off_n = off + 1'b1;
        end
      end
      HOLD: off_n = '0;
      DONE: begin
        if (!bus.start) state_n = IDLE;
      end
      default: state_n = IDLE;
    endcase
    // Channel completion overrides any buf_full seen in the same cycle
    if (accept) begin
      off_n   = '0;
      state_n = FETCH;
      if (mode == 3'(NUM_CH)) begin
        mode_n = 3'd1;
        base_n = base + ADDR_W'(WORDS_PER_BLOCK);
        bidx_n = block_idx + 1'b1;
        if (block_idx == BIDX_W'(BLOCK_NUM - 1)) begin
          state_n = DONE;
          done_n  = 1'b1;
        end
      end else begin
        mode_n = mode + 3'd1;
      end
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state        <= IDLE;
      base         <= '0;
      off          <= '0;
      mode         <= 3'd1;
      block_idx    <= '0;
      addr_q       <= '0;
      addr_valid_q <= 1'b0;
      done_q       <= 1'b0;
    end else begin
      state        <= state_n;
      base         <= base_n;
      off          <= off_n;
      mode         <= mode_n;
      block_idx    <= bidx_n;
      addr_q       <= base_n + ADDR_W'(off_n);
      addr_valid_q <= (state_n == FETCH);
      done_q       <= done_n;
    end
  end

  // Read-data qualifier trails the issued address by the SRAM latency
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      dv_sr <= '0;
    end else begin
      dv_sr[0] <= addr_valid_q;
      for (int i = 1; i < RD_LAT; i++) dv_sr[i] <= dv_sr[i-1];
    end
  end

`ifdef EPU_SCHED_PERF_EN
  logic [15:0] perf_cnt;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      perf_cnt <= '0;
    end else if (state == IDLE && state_n == FETCH) begin
      perf_cnt <= '0;
    end else if (state == HOLD && perf_cnt != 16'hFFFF) begin
      perf_cnt <= perf_cnt + 16'd1;
    end
  end

  assign bus.perf_hold = perf_cnt;
`else
  assign bus.perf_hold = '0;
`endif

  assign bus.addr       = addr_q;
  assign bus.addr_valid = addr_valid_q;
  assign bus.data_valid = dv_sr[RD_LAT-1];
  assign bus.mode       = mode;
  assign bus.block_idx  = block_idx;
  assign bus.busy       = (state == FETCH) || (state == HOLD);
  assign bus.done       = done_q;
endmodule

// File: tb/tb_epu_block_sched.sv
// Directed self-checking bench for epu_block_sched (BLOCK_NUM reduced to 2).
// Expected perf_hold follows EPU_SCHED_PERF_EN.
module tb_epu_block_sched;
  localparam int ADDR_W    = 12;
  localparam int BLOCK_NUM = 2;

  logic clk;
  logic rst;
  int   passed;
  int   total;
  int   done_cnt;

  epu_block_sched_if #(.ADDR_W(ADDR_W), .BLOCK_NUM(BLOCK_NUM)) bus ();

  epu_block_sched #(
    .ADDR_W(ADDR_W), .BLOCK_NUM(BLOCK_NUM), .WORDS_PER_BLOCK(16),
    .NUM_CH(3), .RD_LAT(2)
  ) dut (
    .clk(clk),
    .rst(rst),
    .bus(bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  always @(negedge clk) if (bus.done) done_cnt++;

  task automatic checkOutput(input string tag, input logic [31:0] actual, input logic [31:0] expected);
    total++;
    if (actual === expected) passed++;
    else $display("[TB] FAIL %s: got %0h, expected %0h", tag, actual, expected);
  endtask

  task automatic applyStimulus(input logic s, input logic bf, input logic cd);
    bus.start    = s;
    bus.buf_full = bf;
    bus.ch_done  = cd;
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic checkReset(input string tag);
    checkOutput({tag, ".addr"}, 32'(bus.addr), 32'd0);
    checkOutput({tag, ".addr_valid"}, 32'(bus.addr_valid), 32'd0);
    checkOutput({tag, ".data_valid"}, 32'(bus.data_valid), 32'd0);
    checkOutput({tag, ".mode"}, 32'(bus.mode), 32'd1);
    checkOutput({tag, ".block_idx"}, 32'(bus.block_idx), 32'd0);
    checkOutput({tag, ".busy"}, 32'(bus.busy), 32'd0);
    checkOutput({tag, ".done"}, 32'(bus.done), 32'd0);
    checkOutput({tag, ".perf_hold"}, 32'(bus.perf_hold), 32'd0);
  endtask

  initial begin
    logic [31:0] perf_exp9;
    logic [31:0] perf_exp10;
`ifdef EPU_SCHED_PERF_EN
    perf_exp9  = 32'd9;
    perf_exp10 = 32'd10;
`else
    perf_exp9  = 32'd0;
    perf_exp10 = 32'd0;
`endif
    passed   = 0;
    total    = 0;
    done_cnt = 0;
    applyStimulus(1'b0, 1'b0, 1'b0);
    rst = 1'b0;
    #12;
    checkReset("reset");
    tick();
    rst = 1'b1;
    tick();
    checkOutput("idle.busy", 32'(bus.busy), 32'd0);

    // Free-running fetch: addresses wrap within block 0, data_valid lags by 2
    applyStimulus(1'b1, 1'b0, 1'b0);
    tick();
    for (int i = 0; i < 32; i++) begin
      checkOutput($sformatf("fetch.addr[%0d]", i), 32'(bus.addr), 32'(i % 16));
      checkOutput($sformatf("fetch.av[%0d]", i), 32'(bus.addr_valid), 32'd1);
      checkOutput($sformatf("fetch.dv[%0d]", i), 32'(bus.data_valid), (i >= 2) ? 32'd1 : 32'd0);
      tick();
    end
    checkOutput("fetch.busy", 32'(bus.busy), 32'd1);
    repeat (7) tick();
    checkOutput("pre_hold.addr", 32'(bus.addr), 32'd7);

    // buf_full at addr 7 enters HOLD
    applyStimulus(1'b1, 1'b1, 1'b0);
    tick();
    applyStimulus(1'b1, 1'b0, 1'b0);
    checkOutput("hold.addr", 32'(bus.addr), 32'd0);
    checkOutput("hold.av", 32'(bus.addr_valid), 32'd0);
    checkOutput("hold.busy", 32'(bus.busy), 32'd1);
    checkOutput("hold.dv_drain", 32'(bus.data_valid), 32'd1);
    repeat (9) tick();
    checkOutput("hold10.dv", 32'(bus.data_valid), 32'd0);
    checkOutput("hold10.av", 32'(bus.addr_valid), 32'd0);
    checkOutput("hold10.perf", 32'(bus.perf_hold), perf_exp9);

    // ch_done in HOLD resumes fetching with the next channel
    applyStimulus(1'b1, 1'b0, 1'b1);
    tick();
    applyStimulus(1'b1, 1'b0, 1'b0);
    checkOutput("ch1.mode", 32'(bus.mode), 32'd2);
    checkOutput("ch1.av", 32'(bus.addr_valid), 32'd1);
    checkOutput("ch1.addr", 32'(bus.addr), 32'd0);
    checkOutput("ch1.perf", 32'(bus.perf_hold), perf_exp10);
    tick();
    checkOutput("ch1.addr_next", 32'(bus.addr), 32'd1);

    // ch_done together with buf_full: ch_done wins
    applyStimulus(1'b1, 1'b1, 1'b1);
    tick();
    applyStimulus(1'b1, 1'b0, 1'b0);
    checkOutput("both.mode", 32'(bus.mode), 32'd3);
    checkOutput("both.av", 32'(bus.addr_valid), 32'd1);
    checkOutput("both.addr", 32'(bus.addr), 32'd0);
    tick();
    checkOutput("both.addr_next", 32'(bus.addr), 32'd1);
    checkOutput("both.av_next", 32'(bus.addr_valid), 32'd1);

    // Third channel completes block 0
    applyStimulus(1'b1, 1'b0, 1'b1);
    tick();
    applyStimulus(1'b1, 1'b0, 1'b0);
    checkOutput("blk1.mode", 32'(bus.mode), 32'd1);
    checkOutput("blk1.block_idx", 32'(bus.block_idx), 32'd1);
    checkOutput("blk1.addr", 32'(bus.addr), 32'd16);
    checkOutput("blk1.done", 32'(bus.done), 32'd0);
    tick();
    checkOutput("blk1.addr_next", 32'(bus.addr), 32'd17);

    // Three more channels finish the final block
    for (int c = 0; c < 2; c++) begin
      applyStimulus(1'b1, 1'b0, 1'b1);
      tick();
      applyStimulus(1'b1, 1'b0, 1'b0);
      checkOutput($sformatf("blk1.mode_ch%0d", c + 2), 32'(bus.mode), 32'(c + 2));
      tick();
    end
    applyStimulus(1'b1, 1'b0, 1'b1);
    tick();
    applyStimulus(1'b1, 1'b0, 1'b0);
    checkOutput("final.done", 32'(bus.done), 32'd1);
    checkOutput("final.busy", 32'(bus.busy), 32'd0);
    checkOutput("final.block_idx", 32'(bus.block_idx), 32'd2);
    checkOutput("final.mode", 32'(bus.mode), 32'd1);
    checkOutput("final.av", 32'(bus.addr_valid), 32'd0);
    tick();
    checkOutput("done_after.done", 32'(bus.done), 32'd0);
    applyStimulus(1'b1, 1'b0, 1'b1);
    tick();
    applyStimulus(1'b1, 1'b0, 1'b0);
    repeat (3) tick();
    checkOutput("done_hold.busy", 32'(bus.busy), 32'd0);
    checkOutput("done_hold.mode", 32'(bus.mode), 32'd1);
    checkOutput("done_hold.block_idx", 32'(bus.block_idx), 32'd2);
    checkOutput("done_count", 32'(done_cnt), 32'd1);

    // Restart through IDLE
    applyStimulus(1'b0, 1'b0, 1'b0);
    tick();
    checkOutput("restart_idle.busy", 32'(bus.busy), 32'd0);
    applyStimulus(1'b1, 1'b0, 1'b0);
    tick();
    checkOutput("restart.addr", 32'(bus.addr), 32'd0);
    checkOutput("restart.block_idx", 32'(bus.block_idx), 32'd0);
    checkOutput("restart.av", 32'(bus.addr_valid), 32'd1);
    checkOutput("restart.busy", 32'(bus.busy), 32'd1);
    checkOutput("restart.perf", 32'(bus.perf_hold), 32'd0);

    // Asynchronous reset in the middle of HOLD
    repeat (3) tick();
    applyStimulus(1'b1, 1'b1, 1'b0);
    tick();
    applyStimulus(1'b1, 1'b0, 1'b0);
    tick();
    checkOutput("midhold.busy", 32'(bus.busy), 32'd1);
    #2;
    rst = 1'b0;
    #1;
    checkReset("async_reset");
    tick();
    checkReset("async_reset_held");

    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end
endmodule
